// File: rtl/alu_seq_pkg.sv
// Shared types, opcodes and 7-segment patterns for the 3-bit ALU sequencer.
package alu_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        SHOW = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_AND = 2'b10,
        OP_OR  = 2'b11
    } op_t;

    // Segment patterns, bit7 is the minus sign
    localparam logic [7:0] SEG_ZERO = 8'h3F;
    localparam logic [7:0] SEG_P1   = 8'h06;
    localparam logic [7:0] SEG_P2   = 8'h5B;
    localparam logic [7:0] SEG_P3   = 8'h4F;
    localparam logic [7:0] SEG_M1   = 8'h86;
    localparam logic [7:0] SEG_M2   = 8'hDB;
    localparam logic [7:0] SEG_M3   = 8'hCF;
    localparam logic [7:0] SEG_M4   = 8'hE6;

    // Maps a 3-bit two's complement value to its display pattern
    function automatic logic [7:0] seg_of(input logic [2:0] v);
        logic [7:0] s;
        case (v)
            3'b000:  s = SEG_ZERO;
            3'b001:  s = SEG_P1;
            3'b010:  s = SEG_P2;
            3'b011:  s = SEG_P3;
            3'b111:  s = SEG_M1;
            3'b110:  s = SEG_M2;
            3'b101:  s = SEG_M3;
            3'b100:  s = SEG_M4;
            default: s = SEG_ZERO;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/alu3.sv
// Combinational 3-bit signed ALU: ADD, SUB, AND, OR with signed overflow.
module alu3
    import alu_seq_pkg::*;
(
    input  logic [2:0] a,
    input  logic [2:0] b,
    input  logic [1:0] f,
    output logic [2:0] y,
    output logic       ovf
);

    // Compute the low 3 bits of the operation and its signed overflow
    always_comb begin
        y   = 3'b000;
        ovf = 1'b0;
        case (f)
            OP_ADD: begin
                y   = a + b;
                ovf = (a[2] == b[2]) && (y[2] != a[2]);
            end
            OP_SUB: begin
                y   = a - b;
                ovf = (a[2] != b[2]) && (y[2] != a[2]);
            end
            OP_AND: begin
                y   = a & b;
                ovf = 1'b0;
            end
            OP_OR: begin
                y   = a | b;
                ovf = 1'b0;
            end
            default: begin
                y   = 3'b000;
                ovf = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_sequencer.sv
// Sequencer around alu3: captures operands on start, runs one operation,
// registers result/overflow/segment pattern and holds it for HOLD_CYCLES.
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int HOLD_CYCLES = 4,
    parameter int NBITS_OP    = 3,
    parameter int NBITS_CNT   = 8
) (
    input  logic                 clk_2,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 chain,
    input  logic [NBITS_OP-1:0]  op_a,
    input  logic [NBITS_OP-1:0]  op_b,
    input  logic [1:0]           op_f,
    output logic                 busy,
    output logic                 done,
    output logic [NBITS_OP-1:0]  result,
    output logic                 overflow,
    output logic [7:0]           seg,
    output logic [NBITS_CNT-1:0] op_count,
    output logic [1:0]           state_dbg
);

    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_EXEC = EXEC;
    localparam logic [1:0] S_SHOW = SHOW;

    // Hold counter only needs to reach HOLD_CYCLES-1
    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_ZERO = {HOLD_W{1'b0}};
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
    localparam logic [NBITS_CNT-1:0] CNT_ONE = NBITS_CNT'(1);

    logic [1:0]           state_r;
    logic [1:0]           state_nx_s;
    logic [HOLD_W-1:0]    hold_r;
    logic                 busy_r;
    logic                 done_r;
    logic [NBITS_OP-1:0]  a_r;
    logic [NBITS_OP-1:0]  b_r;
    logic [1:0]           f_r;
    logic [NBITS_OP-1:0]  result_r;
    logic                 ovf_r;
    logic [7:0]           seg_r;
    logic [NBITS_CNT-1:0] cnt_r;
    logic [2:0]           alu_y_s;
    logic                 alu_ovf_s;

    alu3 u_alu (
        .a   (a_r),
        .b   (b_r),
        .f   (f_r),
        .y   (alu_y_s),
        .ovf (alu_ovf_s)
    );

    // Next-state decode; the unused encoding falls back to IDLE
    always_comb begin
        state_nx_s = S_IDLE;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    state_nx_s = S_EXEC;
                end else begin
                    state_nx_s = S_IDLE;
                end
            end
            S_EXEC: state_nx_s = S_SHOW;
            S_SHOW: begin
                if (hold_r == HOLD_ZERO) begin
                    state_nx_s = S_IDLE;
                end else begin
                    state_nx_s = S_SHOW;
                end
            end
            default: state_nx_s = S_IDLE;
        endcase
    end

    // State, status flags and hold counter; reset wins over start
    always_ff @(posedge clk_2) begin
        if (reset) begin
            state_r <= S_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            hold_r  <= HOLD_ZERO;
        end else begin
            state_r <= state_nx_s;
            busy_r  <= (state_nx_s == S_EXEC) || (state_nx_s == S_SHOW);
            done_r  <= (state_r == S_EXEC);
            if (state_r == S_EXEC) begin
                hold_r <= HOLD_LOAD;
            end else if ((state_r == S_SHOW) && (hold_r != HOLD_ZERO)) begin
                hold_r <= hold_r - HOLD_ONE;
            end else begin
                hold_r <= hold_r;
            end
        end
    end

    // Operand capture in IDLE and result registration on leaving EXEC
    always_ff @(posedge clk_2) begin
        if (reset) begin
            a_r      <= {NBITS_OP{1'b0}};
            b_r      <= {NBITS_OP{1'b0}};
            f_r      <= 2'b00;
            result_r <= {NBITS_OP{1'b0}};
            ovf_r    <= 1'b0;
            seg_r    <= SEG_ZERO;
            cnt_r    <= {NBITS_CNT{1'b0}};
        end else begin
            if ((state_r == S_IDLE) && start) begin
                a_r <= chain ? result_r : op_a;
                b_r <= op_b;
                f_r <= op_f;
            end else begin
                a_r <= a_r;
                b_r <= b_r;
                f_r <= f_r;
            end
            if (state_r == S_EXEC) begin
                result_r <= alu_y_s;
                ovf_r    <= alu_ovf_s;
                seg_r    <= seg_of(alu_y_s);
                cnt_r    <= cnt_r + CNT_ONE;
            end else begin
                result_r <= result_r;
                ovf_r    <= ovf_r;
                seg_r    <= seg_r;
                cnt_r    <= cnt_r;
            end
        end
    end

    assign busy      = busy_r;
    assign done      = done_r;
    assign result    = result_r;
    assign overflow  = ovf_r;
    assign seg       = seg_r;
    assign op_count  = cnt_r;
    assign state_dbg = state_r;

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer: a reference model predicts each
// accepted operation, a negedge monitor checks outputs and timing.
module tb_alu_sequencer;

    localparam int HOLD = 4;

    logic       clk_2 = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       chain = 1'b0;
    logic [2:0] op_a  = 3'b000;
    logic [2:0] op_b  = 3'b000;
    logic [1:0] op_f  = 2'b00;
    logic       busy;
    logic       done;
    logic [2:0] result;
    logic       overflow;
    logic [7:0] seg;
    logic [7:0] op_count;
    logic [1:0] state_dbg;

    alu_sequencer #(.HOLD_CYCLES(HOLD), .NBITS_OP(3), .NBITS_CNT(8)) dut (
        .clk_2     (clk_2),
        .reset     (reset),
        .start     (start),
        .chain     (chain),
        .op_a      (op_a),
        .op_b      (op_b),
        .op_f      (op_f),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .overflow  (overflow),
        .seg       (seg),
        .op_count  (op_count),
        .state_dbg (state_dbg)
    );

    always #5 clk_2 = ~clk_2;

    typedef struct {
        logic [2:0] res;
        logic       ovf;
        logic [7:0] seg;
        logic [7:0] cnt;
    } exp_t;

    exp_t       sb[$];
    int         n_tests  = 0;
    int         n_fail   = 0;
    int         cyc      = 0;
    int         acc_edge = -1000;
    bit         mon_en   = 1'b0;
    logic [2:0] m_result = 3'b000;
    int         m_count  = 0;

    function automatic logic [7:0] seg_ref(input int v);
        case (v)
            0:       return 8'h3F;
            1:       return 8'h06;
            2:       return 8'h5B;
            3:       return 8'h4F;
            -1:      return 8'h86;
            -2:      return 8'hDB;
            -3:      return 8'hCF;
            -4:      return 8'hE6;
            default: return 8'h00;
        endcase
    endfunction

    // Reference: signed integer arithmetic, range check, wrap into [-4,3]
    function automatic exp_t predict(input logic [2:0] a, input logic [2:0] b, input logic [1:0] f);
        exp_t e;
        int sa;
        int sb_v;
        int s;
        logic [2:0] bits;
        sa   = (a >= 3'd4) ? int'(a) - 8 : int'(a);
        sb_v = (b >= 3'd4) ? int'(b) - 8 : int'(b);
        e.ovf = 1'b0;
        case (f)
            2'd0: begin s = sa + sb_v; e.ovf = (s > 3) || (s < -4); end
            2'd1: begin s = sa - sb_v; e.ovf = (s > 3) || (s < -4); end
            2'd2: begin bits = a & b; s = (bits >= 3'd4) ? int'(bits) - 8 : int'(bits); end
            default: begin bits = a | b; s = (bits >= 3'd4) ? int'(bits) - 8 : int'(bits); end
        endcase
        if (s > 3) s = s - 8;
        if (s < -4) s = s + 8;
        e.res = s[2:0];
        e.seg = seg_ref(s);
        e.cnt = 8'h00;
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: decides at each edge whether start is accepted and pushes the prediction
    initial begin : model
        exp_t e;
        logic [2:0] a_eff;
        forever begin
            @(posedge clk_2);
            cyc++;
            if (reset) begin
                sb.delete();
                m_result = 3'b000;
                m_count  = 0;
                acc_edge = -1000;
                mon_en   = 1'b1;
            end else if (start && (cyc >= acc_edge + HOLD + 2)) begin
                a_eff    = chain ? m_result : op_a;
                e        = predict(a_eff, op_b, op_f);
                m_count  = (m_count + 1) % 256;
                e.cnt    = 8'(m_count);
                sb.push_back(e);
                m_result = e.res;
                acc_edge = cyc;
            end
        end
    end

    // Monitor: checks state/busy/done timeline every cycle and pops on done
    initial begin : monitor
        int d;
        int es;
        exp_t e;
        forever begin
            @(negedge clk_2);
            if (mon_en) begin
                d  = cyc - acc_edge;
                es = (d == 0) ? 1 : (((d >= 1) && (d <= HOLD)) ? 2 : 0);
                check("state_dbg", 32'(state_dbg), 32'(es));
                check("busy", 32'(busy), 32'(es != 0));
                check("done", 32'(done), 32'(d == 1));
                if (d == 1) begin
                    if (sb.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL scoreboard: done due but no prediction queued");
                    end else begin
                        e = sb.pop_front();
                        check("result", 32'(result), 32'(e.res));
                        check("overflow", 32'(overflow), 32'(e.ovf));
                        check("seg", 32'(seg), 32'(e.seg));
                        check("op_count", 32'(op_count), 32'(e.cnt));
                    end
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk_2);
    endtask

    task automatic issue(input logic ch, input logic [2:0] a, input logic [2:0] b, input logic [1:0] f);
        chain = ch; op_a = a; op_b = b; op_f = f; start = 1'b1;
        tick();
        start = 1'b0; chain = 1'b0;
    endtask

    task automatic wait_done();
        bit got;
        got = 1'b0;
        for (int i = 0; (i < 12) && !got; i++) begin
            tick();
            got = (done === 1'b1);
        end
        if (!got) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_done: no done within 12 cycles");
        end
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; (i < 20) && !ok; i++) begin
            if (busy === 1'b0) ok = 1'b1;
            else tick();
        end
        if (!ok) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_idle: still busy after 20 cycles");
        end
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [7:0] cnt0;
        int nd;

        // Reset state
        tick(); tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_seg", 32'(seg), 32'h3F);
        check("rst_op_count", 32'(op_count), 32'd0);
        check("rst_state", 32'(state_dbg), 32'd0);
        reset = 1'b0;
        tick();

        // 3 + 1 overflows to -4
        issue(1'b0, 3'd3, 3'd1, 2'b00);
        wait_done();
        check("add_result", 32'(result), 32'b100);
        check("add_ovf", 32'(overflow), 32'd1);
        check("add_seg", 32'(seg), 32'hE6);
        check("add_count", 32'(op_count), 32'd1);
        for (int i = 0; i < HOLD; i++) tick();
        check("idle_after_hold", 32'(busy), 32'd0);

        // -4 - 1 overflows to 3, then chained AND keeps 3
        issue(1'b0, 3'b100, 3'd1, 2'b01);
        wait_done();
        check("sub_result", 32'(result), 32'b011);
        check("sub_ovf", 32'(overflow), 32'd1);
        check("sub_seg", 32'(seg), 32'h4F);
        wait_idle();
        issue(1'b1, 3'b000, 3'b111, 2'b10);
        wait_done();
        check("chain_result", 32'(result), 32'b011);
        check("chain_ovf", 32'(overflow), 32'd0);
        wait_idle();

        // start held during busy: one op per HOLD+2 window
        cnt0 = op_count;
        nd = 0;
        start = 1'b1;
        for (int i = 0; i < 3 * (HOLD + 2); i++) begin
            op_a  = 3'($urandom_range(0, 7));
            op_b  = 3'($urandom_range(0, 7));
            op_f  = 2'($urandom_range(0, 3));
            chain = 1'($urandom_range(0, 1));
            tick();
            if (done === 1'b1) nd++;
        end
        start = 1'b0; chain = 1'b0;
        check("burst_dones", 32'(nd), 32'd3);
        wait_idle();
        check("burst_count", 32'(op_count), 32'(8'(cnt0 + 8'd3)));

        // Reset during EXEC, then a fresh OR
        issue(1'b0, 3'd2, 3'd2, 2'b00);
        check("exec_state", 32'(state_dbg), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_state", 32'(state_dbg), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_result", 32'(result), 32'd0);
        check("midrst_count", 32'(op_count), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("midrst_nodone", 32'(done), 32'd0);
        end
        issue(1'b0, 3'd1, 3'd1, 2'b11);
        wait_done();
        check("or_result", 32'(result), 32'b001);
        check("or_seg", 32'(seg), 32'h06);
        wait_idle();

        // 256 x (0+0): counter wraps to 0
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chain = 1'b0; op_a = 3'd0; op_b = 3'd0; op_f = 2'b00; start = 1'b1;
        for (int k = 0; k < 256; k++) wait_done();
        start = 1'b0;
        check("wrap_count", 32'(op_count), 32'd0);
        check("wrap_result", 32'(result), 32'd0);
        check("wrap_ovf", 32'(overflow), 32'd0);
        wait_idle();

        // Random traffic with occasional reset
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 49) == 0);
            start = ($urandom_range(0, 2) == 0);
            chain = 1'($urandom_range(0, 1));
            op_a  = 3'($urandom_range(0, 7));
            op_b  = 3'($urandom_range(0, 7));
            op_f  = 2'($urandom_range(0, 3));
            tick();
        end
        reset = 1'b0; start = 1'b0; chain = 1'b0;
        wait_idle();
        tick(); tick();
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
